// File: rtl/pll_reset_sequencer.sv
// Power-on PLL bring-up and reset-release sequencer, clocked by the free-running reference clock.
// Optional retry limit with terminal FAIL state: define PLL_RETRY_LIMIT_EN.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 64,
  parameter int REL_GAP       = 8,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 16
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic       fail,
  output logic [2:0] state_dbg
);

  // Handshake note: there is no valid/ready pairing here; soft_rst_req is a
  // level sampled every clkin edge, and pll_locked is a raw async level.

  typedef enum logic [2:0] {
    S_PLL_RST    = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_STABLE     = 3'd2,
    S_REL_PERIPH = 3'd3,
    S_RUN        = 3'd4
`ifdef PLL_RETRY_LIMIT_EN
    , S_FAIL     = 3'd5
`endif
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(REL_GAP - 1);

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 1 || REL_GAP < 1)
  begin : g_bad_cycles
    $error("pll_reset_sequencer: cycle parameter out of range");
  end
  if (MAX_RETRIES < 1 || MAX_RETRIES > 255) begin : g_bad_retries
    $error("pll_reset_sequencer: MAX_RETRIES must be 1..255");
  end
  if (CNT_W < 1 || CNT_W > 31 || (LOCK_TIMEOUT - 1) >= (1 << CNT_W) ||
      (RST_CYCLES - 1) >= (1 << CNT_W) || (STABLE_CYCLES - 1) >= (1 << CNT_W) ||
      (REL_GAP - 1) >= (1 << CNT_W)) begin : g_bad_width
    $error("pll_reset_sequencer: CNT_W too small for cycle parameters");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [7:0]       retry_nxt;
  logic [7:0]       retry_sat;
  logic             locked_meta, locked_s;

  // Two-flop synchronizer; every decision below looks only at locked_s.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= pll_locked;
      locked_s    <= locked_meta;
    end
  end

  assign retry_sat = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + CNT_W'(1);
    retry_nxt = retry_cnt;
    case (state)
      S_PLL_RST: begin
        if (timer == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = S_STABLE;
          timer_nxt = '0;
        end else if (timer == TIMEOUT_LAST) begin
          retry_nxt = retry_sat;
          timer_nxt = '0;
`ifdef PLL_RETRY_LIMIT_EN
          if (({1'b0, retry_cnt} + 9'd1) == 9'(MAX_RETRIES))
            state_nxt = S_FAIL;
          else
            state_nxt = S_PLL_RST;
`else
          state_nxt = S_PLL_RST;
`endif
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
        end else if (timer == STABLE_LAST) begin
          state_nxt = S_REL_PERIPH;
          timer_nxt = '0;
        end
      end
      // Lock loss is checked before soft reset so it wins on a shared cycle.
      S_REL_PERIPH: begin
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
        end else if (soft_rst_req) begin
          state_nxt = S_STABLE;
          timer_nxt = '0;
        end else if (timer == GAP_LAST) begin
          state_nxt = S_RUN;
          timer_nxt = '0;
        end
      end
      S_RUN: begin
        timer_nxt = timer;
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
        end else if (soft_rst_req) begin
          state_nxt = S_STABLE;
          timer_nxt = '0;
        end
      end
`ifdef PLL_RETRY_LIMIT_EN
      S_FAIL: begin
        timer_nxt = timer;
      end
`endif
      default: begin
        state_nxt = S_PLL_RST;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PLL_RST;
      timer     <= '0;
      retry_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  // Outputs decode the next state so they change on the edge that enters it.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst      <= 1'b1;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      ready        <= 1'b0;
    end else begin
`ifdef PLL_RETRY_LIMIT_EN
      pll_rst    <= (state_nxt == S_PLL_RST) || (state_nxt == S_FAIL);
`else
      pll_rst    <= (state_nxt == S_PLL_RST);
`endif
      periph_rst_n <= (state_nxt == S_REL_PERIPH) || (state_nxt == S_RUN);
      core_rst_n   <= (state_nxt == S_RUN);
      ready        <= (state_nxt == S_RUN);
    end
  end

`ifdef PLL_RETRY_LIMIT_EN
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) fail <= 1'b0;
    else        fail <= (state_nxt == S_FAIL);
  end
`else
  assign fail = 1'b0;
`endif

  assign state_dbg = state;

endmodule
